// File: rtl/shift_down_ctrl.sv
// Sequencer for the shift_down chain: issues one read instruction per (SMC, word) under
// FIFO credit, matches returns with a latency-aligned tag pipeline and buffers them for the reader.
module shift_down_ctrl #(
  parameter int NUM_SMC           = 8,
  parameter int PARAM_UR_WORD_CNT = 4,
  parameter int RET_LAT           = 8,
  parameter int FIFO_DEPTH        = 8,
  localparam int WIDX_W = (PARAM_UR_WORD_CNT > 1) ? $clog2(PARAM_UR_WORD_CNT) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic [4:0]        cmd_smc_start,
  input  logic [5:0]        cmd_smc_cnt,
  output logic [133:0]      crd_shiftdn_out,
  input  logic [133:0]      crd_shiftdn_ret,
  output logic              rd_vld,
  input  logic              rd_rdy,
  output logic [127:0]      rd_data,
  output logic [4:0]        rd_smc_id,
  output logic [WIDX_W-1:0] rd_word_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic              alive_q;
  logic [4:0]        smc_q, smc_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic [7:0]        remain_q, remain_d;
  logic [CNT_W-1:0]  outst_q;
  logic              err_q;

  logic              out_vld_q;
  logic [127:0]      out_data_q;
  logic [4:0]        out_smc_q;

  logic              tag_live_q [RET_LAT];
  logic [4:0]        tag_smc_q  [RET_LAT];
  logic [WIDX_W-1:0] tag_widx_q [RET_LAT];

  logic [127:0]      mem_data [FIFO_DEPTH];
  logic [4:0]        mem_smc  [FIFO_DEPTH];
  logic [WIDX_W-1:0] mem_widx [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  fifo_cnt_q;

  logic              issue, pop, push, credit, cmd_bad, cmd_err, ret_err;
  logic [6:0]        cmd_end;

  assign cmd_end = {2'b00, cmd_smc_start} + {1'b0, cmd_smc_cnt};
  assign cmd_bad = (cmd_smc_cnt == 6'd0) || (cmd_end > 7'(NUM_SMC));
  assign pop     = rd_vld & rd_rdy;
  assign push    = tag_live_q[RET_LAT-1];
  // Outstanding counts every word from issue until it leaves the FIFO, so it covers tags and occupancy.
  assign credit  = (outst_q < CNT_W'(FIFO_DEPTH)) || pop;
  assign ret_err = push && (!crd_shiftdn_ret[133] || (crd_shiftdn_ret[4:0] != tag_smc_q[RET_LAT-1]));

  always_comb begin
    state_d  = state_q;
    smc_d    = smc_q;
    widx_d   = widx_q;
    remain_d = remain_q;
    issue    = 1'b0;
    cmd_err  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_vld && cmd_rdy) begin
          if (cmd_bad) begin
            cmd_err = 1'b1;
          end else begin
            smc_d    = cmd_smc_start;
            widx_d   = '0;
            remain_d = 8'(cmd_smc_cnt) * 8'(PARAM_UR_WORD_CNT);
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (credit) begin
          issue    = 1'b1;
          remain_d = remain_q - 8'd1;
          if (widx_q == WIDX_W'(PARAM_UR_WORD_CNT - 1)) begin
            widx_d = '0;
            smc_d  = smc_q + 5'd1;
          end else begin
            widx_d = widx_q + WIDX_W'(1);
          end
          if (remain_q == 8'd1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((outst_q == '0) || ((outst_q == CNT_W'(1)) && pop)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      alive_q  <= 1'b0;
      smc_q    <= '0;
      widx_q   <= '0;
      remain_q <= '0;
      outst_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      alive_q  <= 1'b1;
      smc_q    <= smc_d;
      widx_q   <= widx_d;
      remain_q <= remain_d;
      if (cmd_err || ret_err) err_q <= 1'b1;
      case ({issue, pop})
        2'b10:   outst_q <= outst_q + CNT_W'(1);
        2'b01:   outst_q <= outst_q - CNT_W'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

  // Only vld drops on idle cycles; data and ID hold since the chain ignores them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_smc_q  <= '0;
    end else begin
      out_vld_q <= issue;
      if (issue) begin
        out_data_q <= 128'(widx_q);
        out_smc_q  <= smc_q;
      end
    end
  end

  // Tags start from the head register, so the last stage lines up with the chain tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RET_LAT; i++) begin
        tag_live_q[i] <= 1'b0;
        tag_smc_q[i]  <= '0;
        tag_widx_q[i] <= '0;
      end
    end else begin
      tag_live_q[0] <= out_vld_q;
      tag_smc_q[0]  <= out_smc_q;
      tag_widx_q[0] <= out_data_q[WIDX_W-1:0];
      for (int i = 1; i < RET_LAT; i++) begin
        tag_live_q[i] <= tag_live_q[i-1];
        tag_smc_q[i]  <= tag_smc_q[i-1];
        tag_widx_q[i] <= tag_widx_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= crd_shiftdn_ret[132:5];
      mem_smc[wr_ptr_q]  <= tag_smc_q[RET_LAT-1];
      mem_widx[wr_ptr_q] <= tag_widx_q[RET_LAT-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  assign rd_vld          = (fifo_cnt_q != '0);
  assign rd_data         = rd_vld ? mem_data[rd_ptr_q] : '0;
  assign rd_smc_id       = rd_vld ? mem_smc[rd_ptr_q]  : '0;
  assign rd_word_idx     = rd_vld ? mem_widx[rd_ptr_q] : '0;
  assign crd_shiftdn_out = {out_vld_q, out_data_q, out_smc_q};
  assign cmd_rdy         = alive_q && (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);
  assign err             = err_q;

endmodule

// File: doc/shift_down_ctrl.md
Name: shift_down_ctrl

Overview:
- Sequencer for the shift_down chain. It accepts a read-out command covering a contiguous range of SMC IDs and issues one 134-bit shift-down instruction per (SMC, word) into the chain head.
- It captures returned words from the chain tail using a latency-matched tag pipeline, buffers them in a small FIFO and presents them on a valid/ready read port.
- The chain cannot stall, so issue is credit-limited by free FIFO space.

Parameters:
- NUM_SMC, 8, number of shift_down stages; legal SMC IDs 0..NUM_SMC-1 (max 32).
- PARAM_UR_WORD_CNT, 4, 128-bit words read per SMC per command.
- RET_LAT, 8, cycles from instruction issue at the chain head to its word at the chain tail (>=1).
- FIFO_DEPTH, 8, return buffer entries; power of 2, >= 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_vld  in  1  command valid.
- cmd_rdy  out  1  command accepted when cmd_vld & cmd_rdy.
- cmd_smc_start  in  5  first SMC ID.
- cmd_smc_cnt  in  6  number of SMCs (1..NUM_SMC).
- crd_shiftdn_out  out  134  to chain head: {vld[133], data[132:5], smc_id[4:0]}.
- crd_shiftdn_ret  in  134  from chain tail, same format.
- rd_vld  out  1  read word valid.
- rd_rdy  in  1  consumer ready.
- rd_data  out  128  returned word.
- rd_smc_id  out  5  SMC ID of rd_data.
- rd_word_idx  out  2  word index within the SMC, clog2(PARAM_UR_WORD_CNT) bits.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the last word of a command is popped.
- err  out  1  sticky illegal command or return-ID mismatch; cleared by reset only.

Behaviour:
- Reset (async assert, sync release): all outputs 0. FSM=IDLE, FIFO empty, tag pipeline cleared, counters 0, cmd_rdy=0 during reset.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: cmd_rdy=1. Accept on cmd_vld. If cmd_smc_cnt==0 or cmd_smc_start+cmd_smc_cnt>NUM_SMC, set err, stay in IDLE and issue nothing. Otherwise latch the range, clear counters and go to ISSUE.
  - ISSUE: each cycle, if credit is available, drive crd_shiftdn_out={1, 128'h0 with word_idx in data[1:0], smc_id} and advance. word_idx counts 0..PARAM_UR_WORD_CNT-1 and then wraps to 0 with smc_id+1. After the last pair is issued, go to DRAIN.
  - DRAIN: wait until the tag pipeline is empty and the FIFO is empty (all words popped), then go to DONE.
  - DONE: done=1 for exactly 1 cycle, then IDLE. cmd_rdy=0 in all states except IDLE.
- Non-issue cycles: crd_shiftdn_out vld=0. Data and smc_id fields hold their last values; they are don't-care downstream.
- Tag pipeline: RET_LAT-deep shift register of {live, smc_id, word_idx}, loaded on issue. When a live tag reaches the end, capture crd_shiftdn_ret[132:5] with the tag into the FIFO.
- Capture is tag-timed, not vld-timed, because stages hold a stale vld=1 output.
- If ret smc_id != tag smc_id or ret vld=0 on a live tag: set err; the word is still pushed.
- Credit rule: issue only when (FIFO occupancy + live tags in flight) < FIFO_DEPTH, counting same-cycle push/pop. The FIFO must never overflow; overflow is an implementation bug.
- FIFO: first-word-fall-through. rd_vld = !empty. Pop on rd_vld & rd_rdy. Simultaneous push and pop when full or empty is legal and keeps occupancy consistent.
- Total words per command = cmd_smc_cnt*PARAM_UR_WORD_CNT. Counter width is 8 bits.
- rd_rdy may be low indefinitely. Issue stalls through credit and no words are lost.
- Reset mid-command: everything aborts to reset values, no done pulse, in-flight tags are discarded.
- New commands are blocked until DONE, so there is no overlap between commands.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles mid-ISSUE -> all outputs 0, FSM IDLE; after release cmd_rdy=1 and crd_shiftdn_out=0.
- Single SMC: start=3, cnt=1, rd_rdy=1, model stage 3 returns 128'h1111..._0..3 -> instructions issued in 4 consecutive cycles with ids 3,3,3,3; 4 words arrive in order with word_idx 0..3 starting RET_LAT+1 cycles after the first issue; done pulse once; busy falls the cycle after done.
- Full range with backpressure: start=0, cnt=8, rd_rdy=0 -> issue stops after 8 instructions (FIFO_DEPTH); then rd_rdy toggles 1/0 -> all 32 words arrive, SMC order 0..7, no drops or duplicates.
- Illegal command: start=6, cnt=4 -> err=1, no vld=1 on crd_shiftdn_out, cmd_rdy stays 1; cnt=0 gives the same result.
- ID mismatch: return model corrupts smc_id on the 2nd word -> err=1 (sticky), the word is still delivered and the command completes with done.
- Stale-vld immunity: chain tail holds vld=1 with constant data while idle -> FIFO stays empty, rd_vld=0.
